// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: access/exception codes,
// FSM state encoding and the byte-lane helper functions.
package dm_pkg;

  localparam logic [2:0] DMT_W  = 3'd0;
  localparam logic [2:0] DMT_H  = 3'd1;
  localparam logic [2:0] DMT_HU = 3'd2;
  localparam logic [2:0] DMT_B  = 3'd3;
  localparam logic [2:0] DMT_BU = 3'd4;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_ALIGN   = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;
  localparam logic [1:0] EXC_BADTYPE = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } dm_state_e;

  function automatic logic type_legal(input logic [2:0] typ);
    return typ <= DMT_BU;
  endfunction

  function automatic logic misaligned(input logic [2:0] typ, input logic [1:0] a);
    logic mis;
    case (typ)
      DMT_W:          mis = (a != 2'b00);
      DMT_H, DMT_HU:  mis = a[0];
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] be_gen(input logic [2:0] typ, input logic [1:0] a);
    logic [3:0] be;
    case (typ)
      DMT_W:          be = 4'b1111;
      DMT_H, DMT_HU:  be = a[1] ? 4'b1100 : 4'b0011;
      DMT_B, DMT_BU:  be = 4'b0001 << a;
      default:        be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [2:0] typ, input logic [31:0] w);
    logic [31:0] r;
    case (typ)
      DMT_W:          r = w;
      DMT_H, DMT_HU:  r = {2{w[15:0]}};
      DMT_B, DMT_BU:  r = {4{w[7:0]}};
      default:        r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_extract(input logic [2:0] typ, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = a[1] ? w[31:16] : w[15:0];
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (typ)
      DMT_W:   r = w;
      DMT_H:   r = {{16{h[15]}}, h};
      DMT_HU:  r = {16'h0, h};
      DMT_B:   r = {{24{b[7]}}, b};
      DMT_BU:  r = {24'h0, b};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic: byte enables, store-data replication and load extraction.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [2:0]  typ_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wrep_o,
  output logic [31:0] rext_o
);

  always_comb begin
    be_o   = be_gen(typ_i, addr_lo_i);
    wrep_o = wdata_rep(typ_i, wdata_i);
    rext_o = ld_extract(typ_i, addr_lo_i, rword_i);
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store access controller in front of the data memory (IDLE -> ACCESS -> RESP).
// Optional store trace printing is compiled in when DM_TRACE_EN is defined.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_exc,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  dm_state_e         state_q, state_d;
  logic              we_q;
  logic [2:0]        typ_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        exc_q, exc_d;
  logic              capture;

  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] rext;

  dm_lane_unit u_lane (
    .typ_i     (typ_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rword_i   (mem_rdata),
    .be_o      (be),
    .wrep_o    (wrep),
    .rext_o    (rext)
  );

  assign capture = (state_q == StIdle) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d   = 8'd0;
          rdata_d = 32'h0;
          if (!type_legal(req_type)) begin
            exc_d   = EXC_BADTYPE;
            state_d = StResp;
          end else if (misaligned(req_type, req_addr[1:0])) begin
            exc_d   = EXC_ALIGN;
            state_d = StResp;
          end else begin
            exc_d   = EXC_NONE;
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 8'd1;
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          rdata_d = we_q ? 32'h0 : rext;
          exc_d   = EXC_NONE;
          state_d = StResp;
        end else if (cnt_d == TimeoutCnt) begin
          rdata_d = 32'h0;
          exc_d   = EXC_TIMEOUT;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      rdata_q <= 32'h0;
      exc_q   <= EXC_NONE;
      we_q    <= 1'b0;
      typ_q   <= DMT_W;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      if (capture) begin
        we_q    <= req_we;
        typ_q   <= req_type;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Memory and response outputs are forced to zero outside the states that own them.
  always_comb begin
    req_ready  = (state_q == StIdle);
    mem_en     = (state_q == StAccess);
    mem_we     = mem_en & we_q;
    mem_be     = mem_en ? be : 4'b0000;
    mem_addr   = mem_en ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata  = (mem_en && we_q) ? wrep : 32'h0;
    resp_valid = (state_q == StResp);
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_exc   = resp_valid ? exc_q : EXC_NONE;
  end

`ifdef DM_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 32'h0;
    end else if (capture) begin
      pc_q <= req_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StAccess && mem_ack && we_q) begin
      $display("@%08h: *%08h <= %08h", pc_q, addr_q,
               wrep & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}});
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed vector table, randomized transactions
// against an arithmetic reference model, and reset/backpressure sequences.
module tb_dm_access_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_exc   (resp_exc),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  typedef struct {
    bit        we;
    bit [2:0]  typ;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        ack_dly;   // -1: memory never acknowledges
    int        bp;        // cycles of resp_ready = 0
    bit [1:0]  exp_exc;
    bit [3:0]  exp_be;
    bit [31:0] exp_wd;
    bit [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit we, bit [2:0] typ, bit [31:0] addr, bit [31:0] wdata,
                              bit [31:0] rdata, int ack_dly, int bp, bit [1:0] exc,
                              bit [3:0] be, bit [31:0] wd, bit [31:0] rd);
    vec_t v;
    v.we = we; v.typ = typ; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_dly = ack_dly; v.bp = bp; v.exp_exc = exc; v.exp_be = be; v.exp_wd = wd;
    v.exp_rd = rd;
    return v;
  endfunction

  // Reference model: access size in bytes, lane position and extension by plain arithmetic.
  function automatic void model(inout vec_t v);
    int unsigned sz, off, bits;
    longint unsigned lane, mask;
    sz  = (v.typ == 0) ? 4 : ((v.typ <= 2) ? 2 : 1);
    off = v.addr % 4;
    bits = 8 * sz;
    if (v.typ > 4) v.exp_exc = 2'd3;
    else if ((v.addr % sz) != 0) v.exp_exc = 2'd1;
    else if (v.ack_dly < 0) v.exp_exc = 2'd2;
    else v.exp_exc = 2'd0;
    v.exp_be = 4'(((1 << sz) - 1) << off);
    mask = (64'd1 << bits) - 1;
    v.exp_wd = 32'((longint'(v.wdata) & mask) * ((sz == 4) ? 1 : ((sz == 2) ? 32'h0001_0001
                                                                            : 32'h0101_0101)));
    lane = (longint'(v.rdata) >> (8 * off)) & mask;
    if ((v.typ == 1 || v.typ == 3) && lane >= (64'd1 << (bits - 1))) lane = lane - (mask + 1);
    v.exp_rd = (v.we || v.exp_exc != 0) ? 32'h0 : 32'(lane);
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int lat, en_cyc, lat_exp, en_exp;
    logic [31:0] rd_hold;
    logic [1:0]  exc_hold;
    @(negedge clk);
    req_we = v.we; req_type = v.typ; req_addr = v.addr; req_wdata = v.wdata;
    req_pc = $urandom; req_valid = 1'b1; resp_ready = 1'b0;
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = ~req_we;
    lat = 1; en_cyc = 0;
    forever begin
      @(negedge clk);
      if (resp_valid || lat >= 300) break;
      if (mem_en) begin
        en_cyc++;
        if (en_cyc == 1) begin
          chk({tag, " mem_be"}, 32'(mem_be), 32'(v.exp_be));
          chk({tag, " mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
          chk({tag, " mem_we"}, 32'(mem_we), 32'(v.we));
          if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.exp_wd);
        end
        mem_ack = (v.ack_dly == en_cyc - 1);
        mem_rdata = mem_ack ? v.rdata : $urandom;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      lat++;
    end
    if (v.exp_exc == 2'd1 || v.exp_exc == 2'd3) begin lat_exp = 1; en_exp = 0; end
    else if (v.exp_exc == 2'd2) begin lat_exp = TO + 1; en_exp = TO; end
    else begin lat_exp = v.ack_dly + 2; en_exp = v.ack_dly + 1; end
    chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, " mem_en cycles"}, 32'(en_cyc), 32'(en_exp));
    chk({tag, " resp_exc"}, 32'(resp_exc), 32'(v.exp_exc));
    chk({tag, " resp_rdata"}, resp_rdata, v.exp_rd);
    rd_hold = resp_rdata; exc_hold = resp_exc;
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clk); @(negedge clk);
      chk({tag, " bp resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " bp rdata stable"}, resp_rdata, rd_hold);
      chk({tag, " bp exc stable"}, 32'(resp_exc), 32'(exc_hold));
      chk({tag, " bp req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1 chk({tag, " req_ready in resp"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " resp_valid drop"}, 32'(resp_valid), 32'd0);
    chk({tag, " req_ready back"}, 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[12];
  vec_t rv;
  int   stray;

  initial begin
    tbl[0]  = mk(1, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0, 4'hF, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 0, 4'hF, 32'h0, 32'hDEADBEEF);
    tbl[2]  = mk(0, 3, 32'h13, 32'h0,        32'h80123456, 0, 0, 0, 4'h8, 32'h0, 32'hFFFFFF80);
    tbl[3]  = mk(0, 4, 32'h13, 32'h0,        32'h80123456, 0, 0, 0, 4'h8, 32'h0, 32'h00000080);
    tbl[4]  = mk(1, 1, 32'h22, 32'h0000ABCD, 32'h0,        1, 0, 0, 4'hC, 32'hABCDABCD, 32'h0);
    tbl[5]  = mk(0, 1, 32'h21, 32'h0,        32'h0,        0, 0, 1, 4'h0, 32'h0, 32'h0);
    tbl[6]  = mk(0, 6, 32'h20, 32'h0,        32'h0,        0, 0, 3, 4'h0, 32'h0, 32'h0);
    tbl[7]  = mk(0, 0, 32'h40, 32'h0,        32'h0,       -1, 0, 2, 4'hF, 32'h0, 32'h0);
    tbl[8]  = mk(0, 2, 32'h02, 32'h0,        32'h80017FFF, 2, 0, 0, 4'hC, 32'h0, 32'h00008001);
    tbl[9]  = mk(0, 1, 32'h02, 32'h0,        32'h80017FFF, 0, 0, 0, 4'hC, 32'h0, 32'hFFFF8001);
    tbl[10] = mk(0, 0, 32'h10, 32'h0,        32'h12345678, 3, 5, 0, 4'hF, 32'h0, 32'h12345678);
    tbl[11] = mk(1, 3, 32'h11, 32'h000000A5, 32'h0,        0, 2, 0, 4'h2, 32'hA5A5A5A5, 32'h0);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst resp_exc", 32'(resp_exc), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.we    = $urandom_range(0, 1);
      rv.typ   = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.ack_dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      rv.bp    = $urandom_range(0, 3);
      model(rv);
      apply(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of an access drops it with no response.
    @(negedge clk);
    req_we = 1'b0; req_type = 3'd0; req_addr = 32'h50; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst mem_en before", 32'(mem_en), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst mem_en", 32'(mem_en), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd1);
    chk("midrst resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk) reset = 1'b1;
    stray = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid || mem_en) stray++;
    end
    resp_ready = 1'b0;
    chk("midrst no response", 32'(stray), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Load/store access controller directly upstream of the data memory.
- Accepts one load/store request at a time from the pipeline MEM stage over a valid/ready handshake.
- Checks alignment and access type, then drives a word-addressed byte-enable memory port and waits for its acknowledge.
- Returns sign/zero-extended load data, or an exception code, over a valid/ready response handshake.

Parameters:
TIMEOUT, 16, cycles to wait for mem_ack before aborting with a bus-error exception (range 1..255).
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low (deasserted = 1)
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_type  in  3  access type: DMT_W=0, DMT_H=1, DMT_HU=2, DMT_B=3, DMT_BU=4
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
req_pc  in  32  pc of the instruction, for trace output
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_rdata  out  32  extended load data; 0 for stores and exceptions
resp_exc  out  2  EXC_NONE=0, EXC_ALIGN=1, EXC_TIMEOUT=2, EXC_BADTYPE=3
mem_en  out  1  memory access strobe, held until mem_ack
mem_we  out  1  write strobe, valid with mem_en
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid while mem_ack = 1
mem_ack  in  1  memory completes the access

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (reset = 0, asynchronous): state IDLE. All outputs 0 except req_ready = 1. Timeout counter 0. Reset mid-ACCESS drops the access with no response.
- IDLE:
  - req_ready = 1. On req_valid, capture all request fields.
  - If type is illegal (5..7), go to RESP with EXC_BADTYPE.
  - Else if misaligned (H/HU with addr[0] = 1, or W with addr[1:0] != 0), go to RESP with EXC_ALIGN.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_addr, mem_we, mem_be and mem_wdata come from registers.
  - Counter increments each cycle.
  - When mem_ack = 1: latch the extracted load data and go to RESP with EXC_NONE.
  - When the counter reaches TIMEOUT with no ack: go to RESP with EXC_TIMEOUT.
- RESP: resp_valid = 1 and outputs are held stable until resp_ready = 1, then go to IDLE. The next request cannot be accepted in that same cycle.
- Latency: request accepted in cycle 0; mem_en high in cycle 1; an ack in cycle 1 gives resp_valid in cycle 2. Best-case throughput is one request per 3 cycles.
- Byte enables:
  - W: 1111.
  - H/HU: 0011 << (2 * addr[1]).
  - B/BU: 0001 << addr[1:0].
- Store data replication:
  - W: wdata.
  - H: {wdata[15:0], wdata[15:0]}.
  - B: {4{wdata[7:0]}}.
- Load data extraction:
  - The selected lane is taken from mem_rdata.
  - H and B sign-extend from bit 15 and bit 7 of the lane respectively.
  - HU and BU zero-extend.
  - For stores, resp_rdata = 0.

Optional Feature:
DM_TRACE_EN
- Defined: at the ack cycle of every store, simulation prints "@<pc>: *<addr> <= <data>". pc is req_pc; addr is the original byte address; data is the merged word the store produces, i.e. replicated data masked by mem_be, shown as 8-digit hex.
- Undefined: no trace code is compiled, and the RTL is identical in every other respect.

Decomposition:
- Shared package dm_pkg holds:
  - the DMT_* type codes;
  - the EXC_* codes;
  - state encodings;
  - the functions be_gen(type, addr[1:0]), wdata_rep(type, wdata) and ld_extract(type, addr[1:0], word).
- One sub-module, dm_lane_unit (combinational be/replicate/extract), instantiated once.
- FSM and counter live in dm_access_ctrl.

Test Plan:
1. Load SW: req_we = 1, type W, addr 0x10, wdata 0xDEADBEEF, ack on cycle 1 -> mem_be = 1111, mem_addr = 0x10, resp_valid in cycle 2, resp_exc = 0. Then load W from 0x10 with mem_rdata 0xDEADBEEF -> resp_rdata = 0xDEADBEEF.
2. Byte loads: load B/BU from addr 0x13 with mem_rdata 0x80123456 -> mem_be = 1000; B gives 0xFFFFFF80, BU gives 0x00000080.
3. Halfword store: store H to addr 0x22, wdata 0x0000ABCD -> mem_be = 1100, mem_wdata = 0xABCDABCD, mem_addr = 0x20.
4. Misaligned halfword: load H at 0x21 -> mem_en never rises, resp_exc = 1 in cycle 1. Illegal type: req_type = 6 -> resp_exc = 3.
5. Timeout: no mem_ack with TIMEOUT = 16 -> mem_en high for exactly 16 cycles, then resp_exc = 2, resp_rdata = 0.
6. Backpressure and reset: resp_ready = 0 for 5 cycles -> resp_valid/resp_rdata stay stable and req_ready = 0. Assert reset during ACCESS -> mem_en = 0 immediately, req_ready = 1, no response is produced.
